// File: rtl/mem_stage_pkg.sv
// Shared types and encodings for the byte-serial memory stage.
// Imported by mem_stage and load_extend.
package mem_stage_pkg;

  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic       is_store;
    logic [1:0] size;
    logic       uns;
  } mem_op_t;

  // Index of the final byte: 0 for B, 1 for H, 3 for W (size 3 acts as W)
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    unique case (1'b1)
      size == MEM_B: last_idx = 2'd0;
      size == MEM_H: last_idx = 2'd1;
      default:       last_idx = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Assembles a little-endian load word and sign/zero extends it by size.
// Pure combinational; shared with future cache fill paths.
module load_extend
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     word,
  input  logic [1:0]      size,
  input  logic            uns,
  output logic [XLEN-1:0] data
);

  logic sb;
  logic sh;

  assign sb = word[7] & ~uns;
  assign sh = word[15] & ~uns;

  // Select width and fill the upper bits
  always_comb begin
    data = XLEN'(word);
    unique case (1'b1)
      size == MEM_B: data = {{(XLEN-8){sb}}, word[7:0]};
      size == MEM_H: data = {{(XLEN-16){sh}}, word[15:0]};
      default:       data = XLEN'(word);
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RISC-V memory stage: byte-serial loads/stores, ALU pass-through.
// MEM_ALIGN_CHECK_EN adds a misalign output and suppresses misaligned H/W.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [3:0]            in_mem_op,
  input  logic                  in_unsigned,
  input  logic [XLEN-1:0]       in_addr,
  input  logic [XLEN-1:0]       in_store_data,
  input  logic                  in_rd_write,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  output logic                  stall_req,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [XLEN-1:0]       mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  input  logic                  mem_done,
  output logic                  write,
  output logic [REG_ADDR_W-1:0] regw_addr,
  output logic [XLEN-1:0]       regw_data
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                  misalign
`endif
);

  state_t                state;
  mem_op_t               op;
  logic [1:0]            cnt;
  logic [3:0][7:0]       lbuf;
  logic [XLEN-1:0]       addr_q;
  logic [XLEN-1:0]       sdata_q;
  logic                  rdw_q;
  logic [REG_ADDR_W-1:0] rd_q;

  logic                  is_mem;
  logic                  is_store;
  logic [1:0]            size;
  logic                  mis_in;
  logic                  last_byte;
  logic [31:0]           word;
  logic [XLEN-1:0]       ld_data;

  assign is_mem    = in_mem_op[3];
  assign is_store  = in_mem_op[2];
  assign size      = in_mem_op[1:0];
  assign last_byte = mem_done && (cnt == last_idx(op.size));

`ifdef MEM_ALIGN_CHECK_EN
  assign mis_in = is_mem &&
    ((size == MEM_H && in_addr[0]) ||
     (size[1] && in_addr[1:0] != 2'b00));
`else
  assign mis_in = 1'b0;
`endif

  // Overlay the byte arriving now onto the bytes already buffered
  always_comb begin
    word = lbuf;
    word[8*cnt +: 8] = mem_rdata;
  end

  load_extend #(.XLEN(XLEN)) u_ext (
    .word (word),
    .size (op.size),
    .uns  (op.uns),
    .data (ld_data)
  );

  // Memory port and back-pressure follow the registered state
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    stall_req = 1'b0;
    if (state == ST_BUSY) begin
      mem_req   = 1'b1;
      mem_we    = op.is_store;
      mem_addr  = addr_q + XLEN'(cnt);
      mem_wdata = sdata_q[8*cnt +: 8];
      stall_req = ~last_byte;
    end else begin
      stall_req = reset_n & in_valid & is_mem & ~mis_in;
    end
  end

  // Sequencer: accept, step bytes, write back
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      op        <= '0;
      cnt       <= '0;
      lbuf      <= '0;
      addr_q    <= '0;
      sdata_q   <= '0;
      rdw_q     <= 1'b0;
      rd_q      <= '0;
      write     <= 1'b0;
      regw_addr <= '0;
      regw_data <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign  <= 1'b0;
`endif
    end else begin
      write <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign <= 1'b0;
`endif
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (!is_mem) begin
              write     <= in_rd_write && (in_rd_addr != '0);
              regw_addr <= in_rd_addr;
              regw_data <= in_addr;
            end else if (mis_in) begin
`ifdef MEM_ALIGN_CHECK_EN
              misalign <= 1'b1;
`endif
            end else begin
              op.is_store <= is_store;
              op.size     <= size;
              op.uns      <= in_unsigned;
              addr_q      <= in_addr;
              sdata_q     <= in_store_data;
              rdw_q       <= in_rd_write;
              rd_q        <= in_rd_addr;
              cnt         <= '0;
              state       <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (mem_done) begin
            if (last_byte) begin
              state <= ST_IDLE;
              cnt   <= '0;
              if (!op.is_store) begin
                write     <= rdw_q && (rd_q != '0);
                regw_addr <= rd_q;
                regw_data <= ld_data;
              end
            end else begin
              lbuf[cnt] <= mem_rdata;
              cnt       <= cnt + 2'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a byte-array memory model.
// Build with +define+MEM_ALIGN_CHECK_EN to exercise the alignment trap.
module tb_mem_stage;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic [3:0]  in_mem_op;
  logic        in_unsigned;
  logic [31:0] in_addr;
  logic [31:0] in_store_data;
  logic        in_rd_write;
  logic [4:0]  in_rd_addr;
  logic        stall_req;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_done;
  logic        write;
  logic [4:0]  regw_addr;
  logic [31:0] regw_data;
  logic        misalign;

  int n_cmp = 0;
  int n_err = 0;

  bit [7:0] mem [bit [31:0]];

  mem_stage dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_mem_op     (in_mem_op),
    .in_unsigned   (in_unsigned),
    .in_addr       (in_addr),
    .in_store_data (in_store_data),
    .in_rd_write   (in_rd_write),
    .in_rd_addr    (in_rd_addr),
    .stall_req     (stall_req),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_done      (mem_done),
    .write         (write),
    .regw_addr     (regw_addr),
    .regw_data     (regw_data)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .misalign      (misalign)
`endif
  );

`ifndef MEM_ALIGN_CHECK_EN
  assign misalign = 1'b0;
`endif

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit [7:0] rd_mem(input bit [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
  endfunction

  // One instruction, entered and left just after a falling edge
  task automatic run_op(input bit mem_op, input bit st,
                        input bit [1:0] sz, input bit uns,
                        input bit [31:0] a, input bit [31:0] sd,
                        input bit rdw, input bit [4:0] rd,
                        input int maxw);
    int n, cyc, nacc, waits, writes, mis_p, wcnt;
    bit mis, accepted, stl, exp_wr;
    logic [31:0] w, ld, exp_data, got_data;
    logic [4:0] got_rd;
    n = !mem_op ? 0 : (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    mis = 0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 0);
`endif
    w = 0;
    for (int k = 0; k < n; k++)
      w = w | (32'(rd_mem(a + 32'(k))) << (8 * k));
    if (n == 1)
      ld = uns ? (w & 32'hFF) : {{24{w[7]}}, w[7:0]};
    else if (n == 2)
      ld = uns ? (w & 32'hFFFF) : {{16{w[15]}}, w[15:0]};
    else
      ld = w;
    exp_wr = (!mem_op || (!st && !mis)) && rdw && (rd != 0);
    exp_data = mem_op ? ld : a;
    if (mis) n = 0;
    in_valid = 1;
    in_mem_op = {mem_op, st, sz};
    in_unsigned = uns;
    in_addr = a;
    in_store_data = sd;
    in_rd_write = rdw;
    in_rd_addr = rd;
    cyc = 0; nacc = 0; waits = 0; writes = 0; mis_p = 0;
    accepted = 0; got_data = 0; got_rd = 0;
    wcnt = $urandom_range(0, maxw);
    while (!accepted && cyc < 200) begin
      if (mem_req) begin
        if (wcnt == 0) begin
          mem_done = 1;
          if (nacc < n) begin
            chk("acc_addr", mem_addr, a + 32'(nacc));
            chk("acc_we", 32'(mem_we), 32'(st));
            if (st) begin
              chk("acc_wdata", 32'(mem_wdata), (sd >> (8 * nacc)) & 32'hFF);
              mem[a + 32'(nacc)] = 8'((sd >> (8 * nacc)) & 32'hFF);
            end
          end
          mem_rdata = st ? 8'($urandom) : rd_mem(mem_addr);
          nacc++;
          wcnt = $urandom_range(0, maxw);
        end else begin
          mem_done = 0;
          waits++;
          wcnt--;
        end
      end else begin
        mem_done = 1'($urandom);
        mem_rdata = 8'($urandom);
      end
      #1;
      stl = stall_req;
      @(posedge clock);
      #1;
      cyc++;
      if (write) begin
        writes++;
        got_rd = regw_addr;
        got_data = regw_data;
      end
      if (misalign) mis_p++;
      if (!stl) begin
        accepted = 1;
        in_valid = 0;
      end
      @(negedge clock);
    end
    if (!accepted) chk("accept_timeout", 0, 1);
    for (int i = 0; i < 2; i++) begin
      mem_done = 1'($urandom);
      mem_rdata = 8'($urandom);
      @(posedge clock);
      #1;
      if (write) writes++;
      if (misalign) mis_p++;
      @(negedge clock);
    end
    mem_done = 0;
    chk("cycles", cyc, (n == 0) ? 1 : 1 + n + waits);
    chk("accesses", nacc, n);
    chk("writes", writes, exp_wr ? 1 : 0);
    chk("misalign", mis_p, mis ? 1 : 0);
    if (exp_wr) begin
      chk("regw_addr", 32'(got_rd), 32'(rd));
      chk("regw_data", got_data, exp_data);
    end
    chk("idle_req", 32'(mem_req), 0);
  endtask

  // LW interrupted by reset after its second byte
  task automatic reset_mid_access(input bit [31:0] a);
    int dones;
    dones = 0;
    in_valid = 1;
    in_mem_op = 4'b1010;
    in_unsigned = 0;
    in_addr = a;
    in_rd_write = 1;
    in_rd_addr = 5'd7;
    for (int c = 0; c < 20 && dones < 2; c++) begin
      mem_done = mem_req;
      mem_rdata = rd_mem(mem_addr);
      if (mem_req) dones++;
      @(posedge clock);
      #1;
      chk("rst_pre_write", 32'(write), 0);
      @(negedge clock);
    end
    mem_done = 0;
    chk("rst_pre_req", 32'(mem_req), 1);
    reset_n = 0;
    #1;
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_stall", 32'(stall_req), 0);
    in_valid = 0;
    @(posedge clock);
    #1;
    chk("rst_write", 32'(write), 0);
    chk("rst_regw_data", regw_data, 0);
    @(negedge clock);
    reset_n = 1;
    @(negedge clock);
  endtask

  initial begin
    bit [1:0] sz;
    bit [31:0] a;
    clock = 0;
    reset_n = 0;
    in_valid = 0;
    in_mem_op = 0;
    in_unsigned = 0;
    in_addr = 0;
    in_store_data = 0;
    in_rd_write = 0;
    in_rd_addr = 0;
    mem_rdata = 0;
    mem_done = 0;
    #2;
    chk("rst_stall_req", 32'(stall_req), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_write0", 32'(write), 0);
    chk("rst_regw", {27'd0, regw_addr} | regw_data, 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1;
    @(negedge clock);

    run_op(0, 0, 0, 0, 32'h12345678, 0, 1, 5'd5, 0);
    mem[32'h100] = 8'h78; mem[32'h101] = 8'h56;
    mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
    run_op(1, 0, 2, 0, 32'h100, 0, 1, 5'd3, 1);
    mem[32'h3] = 8'h80;
    run_op(1, 0, 0, 0, 32'h3, 0, 1, 5'd4, 1);
    run_op(1, 0, 0, 1, 32'h3, 0, 1, 5'd4, 0);
    mem[32'h4] = 8'h00; mem[32'h5] = 8'h80;
    run_op(1, 0, 1, 0, 32'h4, 0, 1, 5'd6, 1);
    run_op(1, 1, 1, 0, 32'hFFFFFFFF, 32'hAABBCCDD, 1, 5'd9, 1);
    run_op(1, 0, 1, 0, 32'hFFFFFFFF, 0, 1, 5'd9, 0);
    run_op(1, 0, 2, 0, 32'h100, 0, 1, 5'd0, 1);
    run_op(0, 0, 0, 0, 32'hDEADBEEF, 0, 1, 5'd0, 0);
    run_op(1, 0, 2, 0, 32'h102, 0, 1, 5'd8, 1);
    run_op(1, 0, 3, 0, 32'h200, 0, 1, 5'd10, 2);
    reset_mid_access(32'h100);
    run_op(1, 0, 2, 0, 32'h100, 0, 1, 5'd11, 1);

    for (int i = 0; i < 200; i++) begin
      sz = 2'($urandom);
      case ($urandom % 3)
        0: a = 32'h40 + ($urandom % 32);
        1: a = 32'hFFFFFFFC + ($urandom % 4);
        default: a = $urandom;
      endcase
      if ($urandom % 4 == 0)
        run_op(0, 0, 0, 0, $urandom, 0, 1'($urandom), 5'($urandom), 0);
      else
        run_op(1, 1'($urandom), sz, 1'($urandom), a, $urandom,
               1'($urandom), 5'($urandom), 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
